// File: rtl/uart_config_handler.sv
// UART configuration handler: forwards RX bytes, detects the SYN request sequence and
// decodes configuration packets into the active {data_width, parity_mode, stop_bits}.
// Optional packet acknowledge outputs are enabled with `define UART_CONFIG_ACK_EN.

package uart_config_pkg;
    localparam int unsigned SYN_NUMBER = 3;
    localparam logic [7:0]  SYN_BYTE   = 8'h16;

    typedef struct packed {
        logic [1:0] data_width;
        logic [1:0] parity_mode;
        logic [1:0] stop_bits;
    } uart_config_s;

    localparam uart_config_s STD_CONFIGURATION = 6'b11_00_00;
endpackage

module uart_config_handler
    import uart_config_pkg::*;
#(
    parameter int unsigned SYN_COUNT      = SYN_NUMBER,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    input  logic [5:0] sw_cfg_i,
    input  logic       sw_cfg_we_i,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    output logic [5:0] config_o,
    output logic       config_busy_o,
    output logic       config_req_o,
    output logic       config_done_o,
`ifdef UART_CONFIG_ACK_EN
    output logic       config_fail_o,
    output logic [7:0] ack_data_o,
    output logic       ack_valid_o
`else
    output logic       config_fail_o
`endif
);

    localparam int unsigned SYN_W = $clog2(SYN_COUNT + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        MAIN   = 2'd0,
        CONFIG = 2'd1,
        COMMIT = 2'd2
    } state_e;

    state_e             state;
    logic [SYN_W-1:0]   syn_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    uart_config_s       cfg_q;
    uart_config_s       shadow;

    logic [1:0]         pkt_id;
    logic [1:0]         pkt_opt;
    logic               syn_hit;
    logic               sw_legal;
    uart_config_s       snap_c;

    assign pkt_id   = rx_data_i[1:0];
    assign pkt_opt  = rx_data_i[3:2];
    assign syn_hit  = (rx_data_i == SYN_BYTE) && (syn_cnt == SYN_W'(SYN_COUNT - 1));
    assign sw_legal = ~sw_cfg_i[1];
    assign config_o = cfg_q;

    // Configuration the shadow starts from when a request sequence completes
    always_comb begin
        snap_c = cfg_q;
        if (state == COMMIT)
            snap_c = shadow;
        else if (sw_cfg_we_i && sw_legal)
            snap_c = uart_config_s'(sw_cfg_i);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= MAIN;
            syn_cnt       <= '0;
            tmo_cnt       <= '0;
            cfg_q         <= STD_CONFIGURATION;
            shadow        <= STD_CONFIGURATION;
            data_o        <= 8'h00;
            data_valid_o  <= 1'b0;
            config_busy_o <= 1'b0;
            config_req_o  <= 1'b0;
            config_done_o <= 1'b0;
            config_fail_o <= 1'b0;
`ifdef UART_CONFIG_ACK_EN
            ack_data_o    <= 8'h00;
            ack_valid_o   <= 1'b0;
`endif
        end else begin
            data_valid_o  <= 1'b0;
            config_req_o  <= 1'b0;
            config_done_o <= 1'b0;
            config_fail_o <= 1'b0;
`ifdef UART_CONFIG_ACK_EN
            ack_valid_o   <= 1'b0;
`endif
            case (state)
                CONFIG: begin
                    if (rx_valid_i) begin
                        tmo_cnt <= '0;
`ifdef UART_CONFIG_ACK_EN
                        ack_valid_o <= 1'b1;
                        ack_data_o  <= {4'b0000, pkt_opt, pkt_id};
`endif
                        case (pkt_id)
                            2'b01: shadow.data_width  <= pkt_opt;
                            2'b10: shadow.parity_mode <= pkt_opt;
                            2'b11: begin
                                if (pkt_opt[1]) begin
                                    state         <= MAIN;
                                    config_busy_o <= 1'b0;
                                    config_fail_o <= 1'b1;
`ifdef UART_CONFIG_ACK_EN
                                    ack_data_o    <= 8'hFF;
`endif
                                end else begin
                                    shadow.stop_bits <= pkt_opt;
                                end
                            end
                            default: begin
                                state         <= COMMIT;
                                config_busy_o <= 1'b0;
                            end
                        endcase
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        state         <= MAIN;
                        config_busy_o <= 1'b0;
                        config_fail_o <= 1'b1;
`ifdef UART_CONFIG_ACK_EN
                        ack_valid_o   <= 1'b1;
                        ack_data_o    <= 8'hFF;
`endif
                    end else if (!(&tmo_cnt)) begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                default: begin
                    // COMMIT behaves like MAIN for incoming bytes; its software write is dropped
                    if (state == COMMIT) begin
                        cfg_q         <= shadow;
                        config_done_o <= 1'b1;
                        state         <= MAIN;
                    end else if (sw_cfg_we_i) begin
                        if (sw_legal)
                            cfg_q <= uart_config_s'(sw_cfg_i);
                        else
                            config_fail_o <= 1'b1;
                    end

                    if (rx_valid_i) begin
                        data_o       <= rx_data_i;
                        data_valid_o <= 1'b1;
                        if (syn_hit) begin
                            syn_cnt       <= '0;
                            shadow        <= snap_c;
                            tmo_cnt       <= '0;
                            state         <= CONFIG;
                            config_busy_o <= 1'b1;
                            config_req_o  <= 1'b1;
                        end else if (rx_data_i == SYN_BYTE) begin
                            syn_cnt <= syn_cnt + SYN_W'(1);
                        end else begin
                            syn_cnt <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule
